mod_down_timer: RTL

- Parametrised cascade of modulo-N down-counting digits, generalising the single mod-6 digit used in the microwave timer.
- Default configuration is mm:ss: ones of seconds mod 10, tens of seconds mod 6, ones of minutes mod 10, tens of minutes mod 10.
- Sits between the keypad/load logic and the 7-segment display drivers.
- Flags expiry (done) to the microwave control FSM.

---
 rtl/mod_down_timer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mod_down_timer.sv
// mod_down_timer: a cascade of modulo-N down-counting digits. The default
// build is an mm:ss display timer (moduli 10, 6, 10, 10 from digit 0 up).
//
// Each DIGIT_MODS field holds one digit's modulus. A field value of 0 stands
// for 2^DIGIT_W, the one legal modulus that does not fit in DIGIT_W bits.
// A field value of 1 is rejected at elaboration time.
//
// Optional feature, macro TIMER_WRAP_EN: while the count is all zero and en
// is high, every digit reloads to MOD_i-1 instead of holding at zero.
module mod_down_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MODS = 16'hAA6A
) (
  input  logic                          clock,
  input  logic                          clearn,
  input  logic                          loadn,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          zero,
  output logic                          tc,
  output logic                          done
);

  localparam int                  TOTAL_W = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0]  ONE     = DIGIT_W'(1);

  // Largest value of each digit (MOD_i - 1). A field of 0 wraps to all ones,
  // which is exactly 2^DIGIT_W - 1.
  function automatic logic [TOTAL_W-1:0] f_max_vals(input logic [TOTAL_W-1:0] mods);
    logic [TOTAL_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[i*DIGIT_W +: DIGIT_W] = mods[i*DIGIT_W +: DIGIT_W] - ONE;
    end
    return res;
  endfunction

  localparam logic [TOTAL_W-1:0] MAX_VALS = f_max_vals(DIGIT_MODS);

  // Reject any digit whose modulus is 1.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_mod_check
    if (DIGIT_MODS[gi*DIGIT_W +: DIGIT_W] == ONE) begin : g_bad_mod
      $error("mod_down_timer: DIGIT_MODS digit %0d has illegal modulus 1", gi);
    end
  end

  logic [TOTAL_W-1:0] r_digits;
  logic               r_done;

  logic [TOTAL_W-1:0] w_load_val;
  logic [TOTAL_W-1:0] w_dec_val;
  logic [TOTAL_W-1:0] w_next;
  logic [DIGIT_W-1:0] w_cur;
  logic [DIGIT_W-1:0] w_max;
  logic               w_borrow;
  logic               w_zero;
  logic               w_count_ok;
  logic               w_next_done;

  assign w_zero = (r_digits == '0);

  // Saturated load value and borrow-chain decrement value for every digit.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_load_val = '0;
    w_dec_val  = r_digits;
    w_borrow   = 1'b1;
    w_cur      = '0;
    w_max      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_cur = r_digits[i*DIGIT_W +: DIGIT_W];
      w_max = MAX_VALS[i*DIGIT_W +: DIGIT_W];
      w_load_val[i*DIGIT_W +: DIGIT_W] =
        (data[i*DIGIT_W +: DIGIT_W] > w_max) ? w_max : data[i*DIGIT_W +: DIGIT_W];
      if (w_borrow) begin
        w_dec_val[i*DIGIT_W +: DIGIT_W] = (w_cur == '0) ? w_max : (w_cur - ONE);
      end
      // Higher digits only move while every lower digit sits at zero.
      w_borrow = w_borrow & (w_cur == '0);
    end
  end

  // Next count: clear dominates (async), then load, then enabled decrement.
  always_comb begin
`ifdef TIMER_WRAP_EN
    w_count_ok = 1'b1;
`else
    w_count_ok = ~w_zero;
`endif
    w_next      = r_digits;
    w_next_done = 1'b0;
    if (!loadn) begin
      w_next = w_load_val;
    end else if (en && w_count_ok) begin
      w_next      = w_dec_val;
      w_next_done = ~w_zero & (w_dec_val == '0);
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_digits <= '0;
    end else begin
      r_digits <= w_next;
    end
  end

  // Expiry pulse: high for the one cycle after a nonzero-to-zero decrement.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_next_done;
    end
  end

  assign digits = r_digits;
  assign zero   = w_zero;
  assign tc     = en & w_zero;
  assign done   = r_done;

endmodule
